// File: rtl/nbbpu_bus_pkg.sv
// Shared types and decode helpers for the NBBPU data-bus arbiter.
// Read-owner tags steer returning RAM or status data to the right master.
package nbbpu_bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_CPU_IO,
        OWN_LDR
    } rd_owner_t;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFFF0;

    function automatic logic is_io(
        input logic [15:0] addr,
        input logic [15:0] base
    );
        return addr >= base;
    endfunction

endpackage

// File: rtl/io_status_reg.sv
// CPU I/O window status register; status_valid pulses the cycle
// after every I/O write so board logic can latch the program result.
module io_status_reg (
    input  logic        clock,
    input  logic        reset,
    input  logic        write,
    input  logic [15:0] write_data,
    output logic [15:0] status,
    output logic        status_valid
);

    always_ff @(posedge clock) begin
        if (reset) begin
            status       <= 16'h0000;
            status_valid <= 1'b0;
        end else begin
            status_valid <= write;
            if (write) begin
                status <= write_data;
            end
        end
    end

endmodule

// File: rtl/nbbpu_bus_arbiter.sv
// Arbitrates the single-port data RAM between the NBBPU and a loader,
// with bounded loader bursts and a status register in the I/O window.
module nbbpu_bus_arbiter
    import nbbpu_bus_pkg::*;
#(
    parameter logic [15:0] IO_BASE   = IO_BASE_DEFAULT,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read_enable,
    input  logic        cpu_write_enable,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_write_data,
    output logic [15:0] cpu_read_data,
    output logic        cpu_stall,
    input  logic        ldr_request,
    input  logic        ldr_write,
    input  logic [15:0] ldr_address,
    input  logic [15:0] ldr_write_data,
    output logic        ldr_grant,
    output logic        ldr_ack,
    output logic [15:0] ldr_read_data,
    output logic        ram_read_enable,
    output logic        ram_write_enable,
    output logic [15:0] ram_address,
    output logic [15:0] ram_write_data,
    input  logic [15:0] ram_read_data,
    output logic [15:0] status,
    output logic        status_valid
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    rd_owner_t   rd_owner;
    rd_owner_t   owner_next;
    logic [7:0]  burst_count;
    logic [15:0] cpu_hold;
    logic        ldr_rd_ram;
    logic        cpu_req;
    logic        cpu_io;
    logic        cpu_ram;
    logic        ldr_io;
    logic        ldr_win;
    logic        cpu_win;

    assign cpu_req = cpu_read_enable | cpu_write_enable;
    assign cpu_io  = cpu_req & is_io(cpu_address, IO_BASE);
    assign cpu_ram = cpu_req & ~is_io(cpu_address, IO_BASE);
    assign ldr_io  = is_io(ldr_address, IO_BASE);

    // Loader keeps the bus until the burst budget runs out with the CPU waiting.
    assign ldr_win = ~reset & ldr_request
                   & (~cpu_ram | (burst_count < BURST_MAX));
    assign cpu_win = ~reset & cpu_ram & ~ldr_win;

    assign ldr_grant = ldr_win;
    assign cpu_stall = ~reset & cpu_ram & ~cpu_win;

    always_comb begin
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        ram_address      = 16'h0000;
        ram_write_data   = 16'h0000;
        if (cpu_win) begin
            ram_write_enable = cpu_write_enable;
            ram_read_enable  = ~cpu_write_enable;
            ram_address      = cpu_address;
            ram_write_data   = cpu_write_data;
        end else if (ldr_win & ~ldr_io) begin
            ram_write_enable = ldr_write;
            ram_read_enable  = ~ldr_write;
            ram_address      = ldr_address;
            ram_write_data   = ldr_write_data;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (~reset & cpu_io & ~cpu_write_enable) begin
            owner_next = OWN_CPU_IO;
        end else if (cpu_win & ~cpu_write_enable) begin
            owner_next = OWN_CPU;
        end else if (ldr_win & ~ldr_write & ~ldr_io) begin
            owner_next = OWN_LDR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_owner    <= OWN_NONE;
            burst_count <= 8'd0;
            cpu_hold    <= 16'h0000;
            ldr_ack     <= 1'b0;
            ldr_rd_ram  <= 1'b0;
        end else begin
            rd_owner   <= owner_next;
            cpu_hold   <= cpu_read_data;
            ldr_ack    <= ldr_win;
            // Tracked apart from rd_owner: a loader read may share a cycle
            // with a CPU status read.
            ldr_rd_ram <= ldr_win & ~ldr_write & ~ldr_io;
            if (cpu_win | ~ldr_request) begin
                burst_count <= 8'd0;
            end else if (ldr_win & cpu_ram) begin
                burst_count <= burst_count + 8'd1;
            end
        end
    end

    always_comb begin
        unique case (rd_owner)
            OWN_CPU:    cpu_read_data = ram_read_data;
            OWN_CPU_IO: cpu_read_data = status;
            default:    cpu_read_data = cpu_hold;
        endcase
    end

    assign ldr_read_data = (ldr_ack & ldr_rd_ram) ? ram_read_data : 16'h0000;

    io_status_reg u_status (
        .clock        (clock),
        .reset        (reset),
        .write        (cpu_io & cpu_write_enable),
        .write_data   (cpu_write_data),
        .status       (status),
        .status_valid (status_valid)
    );

endmodule

// File: doc/nbbpu_bus_arbiter.md
# nbbpu_bus_arbiter

Shares the single-port data RAM between the NBBPU data port and a secondary loader/debug master. It grants at most one RAM access per cycle and stalls the CPU while the loader holds the bus. It bounds loader bursts so the CPU cannot starve. It also decodes the I/O window at `IO_BASE` into a status register, which the bench and board logic use as the program result/exit port. It sits between `nbbpu`/loader and `ram`, inside the top-level SoC and the verification benches.

## Interface
- `IO_BASE`, default 16'hFFF0: lowest address of the CPU I/O window; addresses >= `IO_BASE` never reach RAM.
- `MAX_BURST`, default 8: maximum consecutive loader grants while the CPU is waiting (range 1..255).
- Clocking: one clock; reset is synchronous and active-high.

Ports:
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_read_enable`  in  1  CPU read request.
- `cpu_write_enable`  in  1  CPU write request.
- `cpu_address`  in  16  CPU address.
- `cpu_write_data`  in  16  CPU write data.
- `cpu_read_data`  out  16  read data, valid the cycle after grant.
- `cpu_stall`  out  1  CPU must hold its request and PC this cycle.
- `ldr_request`  in  1  loader request, held until granted.
- `ldr_write`  in  1  1 = write, 0 = read.
- `ldr_address`  in  16  loader address.
- `ldr_write_data`  in  16  loader write data.
- `ldr_grant`  out  1  loader access issued this cycle.
- `ldr_ack`  out  1  pulse one cycle after grant.
- `ldr_read_data`  out  16  valid while `ldr_ack` = 1.
- `ram_read_enable`  out  1  to `ram`.
- `ram_write_enable`  out  1  to `ram`.
- `ram_address`  out  16  to `ram`.
- `ram_write_data`  out  16  to `ram`.
- `ram_read_data`  in  16  from `ram`; synchronous, 1-cycle latency.
- `status`  out  16  last value the CPU wrote to the I/O window.
- `status_valid`  out  1  one-cycle pulse after each I/O write.

## Operation
- CPU request is `cpu_read_enable | cpu_write_enable`. If both are set, the access is treated as a write.
- A CPU I/O access is one with `cpu_address >= IO_BASE`. It never uses RAM, is never stalled, and may coincide with a loader grant.
  - Write: `status <= cpu_write_data`.
  - Read: returns `status` next cycle.
- Arbitration between a CPU RAM request and a loader request:
  - Only one requester: that requester is granted.
  - Both requesting, `burst_count < MAX_BURST`: loader wins and `burst_count` increments.
  - Both requesting, `burst_count == MAX_BURST`: CPU wins and `burst_count` clears.
- `burst_count` (8 bit) clears on any CPU grant and on any cycle with `ldr_request` = 0.
- `cpu_stall = cpu RAM request & ~cpu granted`. The stall is combinational, in the same cycle.
- The RAM mux is combinational from the granted requester. With no grant, all RAM enables are 0.
- Loader accesses with address >= `IO_BASE` are dropped: no RAM enable is driven, but `ldr_ack` still pulses and `ldr_read_data` = 0.
- A registered `rd_owner` ∈ {NONE, CPU, CPU_IO, LDR} records the source of the previous cycle's read. It steers `ram_read_data` or `status` to the correct port.
- `cpu_read_data` holds its last value when not updated.

## Timing
- Reset (any cycle, including mid-access): all outputs 0, `status` 0, `burst_count` 0, `rd_owner` NONE. Any pending `ldr_ack` is dropped.
- Cycle N: grant and RAM enables are driven. Cycle N+1: read data is valid on the owner's port, and `ldr_ack` or `status_valid` is high.
- Writes commit at the rising edge ending cycle N.
- A write and a read to the same address in consecutive cycles returns the new data.
- Worst-case CPU stall is `MAX_BURST` cycles. After that, the CPU is guaranteed one grant before the loader is granted again.
- Loader throughput is one access per cycle when uncontended; back-to-back grants are legal.

## Structure
- Package `nbbpu_bus_pkg`:
  - `rd_owner` enum (NONE, CPU, CPU_IO, LDR).
  - Default `IO_BASE` localparam.
  - Request-decode function `is_io(addr)`.
- Sub-module `io_status_reg`: holds the `status` register and generates `status_valid`.
- Arbiter FSM, burst counter and RAM mux are in the top module.

## Test plan
- CPU only: write 16'h1234 to 16'h0010, read it back. Expect no stall, `ram_write_enable` for 1 cycle, and `cpu_read_data` = 16'h1234 one cycle after the read grant.
- Contention, `MAX_BURST` = 8: loader and CPU request continuously. Expect 8 loader grants, 1 CPU grant, then repeat; `cpu_stall` high for exactly 8 cycles per CPU access.
- I/O write: CPU writes 1 to 16'hFFF0 during a loader burst. Expect `status` = 1, `status_valid` pulse next cycle, no RAM write, loader not interrupted, CPU not stalled.
- Loader read: preload 16'hBEEF at 16'h0100, loader reads it. Expect `ldr_grant` in cycle N, `ldr_ack` with `ldr_read_data` = 16'hBEEF in N+1. A loader read of 16'hFFF4 gives `ldr_ack` with data 0 and no RAM enable.
- Reset mid-burst: assert `reset` while a loader grant is active. Next cycle: all outputs 0, no `ldr_ack`; after release, a CPU request is granted immediately.
- Simultaneous read+write enables from the CPU to 16'h0020 with data 16'h00AA: treated as a write; memory holds 16'h00AA.
